// File: rtl/drive_mode_arbiter.sv
// drive_mode_arbiter: power sequencing and driving-mode handover for a car.
// Grants one of three driving modules (manual, semi-auto, auto) access to the
// car bus. Every mode switch passes through a handover gap in which no module
// is granted. All outputs are registered.
//
// Parameters
//   PWR_HOLD    cycles pwr_on_btn must be held to power up
//   GAP_CYCLES  length of the handover gap
// Ports
//   clk, rst            clock, synchronous active-high reset
//   pwr_on_btn          power-on button (level, must be held)
//   pwr_off_btn         power-off button (level, highest priority)
//   mode_req[1:0]       requested mode: 00 none, 01 manual, 10 semi, 11 auto
//   man_out/semi_out/auto_out[7:0]  driving module output buses
//   man_p               manual module power-keep flag (0 = misoperation)
//   mode[1:0]           granted mode
//   car_out[7:0]        bus to the car, from the granted module or 0
//   power               car powered
//   busy                handover gap in progress
// Build option
//   FAULT_SHUTDOWN_EN   when defined, man_p=0 during manual RUN (3rd cycle
//                       onward) powers the car off.

module drive_mode_arbiter #(
    parameter int unsigned PWR_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_on_btn,
    input  logic       pwr_off_btn,
    input  logic [1:0] mode_req,
    input  logic [7:0] man_out,
    input  logic       man_p,
    input  logic [7:0] semi_out,
    input  logic [7:0] auto_out,
    output logic [1:0] mode,
    output logic [7:0] car_out,
    output logic       power,
    output logic       busy
);

    localparam int unsigned HOLD_W = (PWR_HOLD > 1) ? $clog2(PWR_HOLD) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_MAN  = 2'b01;
    localparam logic [1:0] MODE_SEMI = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [1:0]          target_q, target_d;
    logic [1:0]          req_s1_q, req_s1_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          mode_q, mode_d;
    logic [7:0]          car_out_q, car_out_d;
    logic                power_q, power_d;
    logic                busy_q, busy_d;
    logic                fault_c;

`ifdef FAULT_SHUTDOWN_EN
    // RUN-cycle counter, saturating at 3; the fault is armed from value 2.
    logic [1:0] run_q, run_d;

    always_comb begin : run_cnt_comb
        run_d = 2'd0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin : run_cnt_reg
        if (rst) begin
            run_q <= 2'd0;
        end else begin
            run_q <= run_d;
        end
    end

    assign fault_c = (mode_q == MODE_MAN) && (run_q >= 2'd2) && !man_p;
`else
    logic unused_man_p;
    assign unused_man_p = man_p;
    assign fault_c      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters, target and request debounce.
    always_comb begin : next_state_comb
        state_d  = state_q;
        hold_d   = '0;
        gap_d    = gap_q;
        target_d = target_q;
        req_s1_d = mode_req;
        // A request counts once two consecutive samples agree.
        deb_d    = (mode_req == req_s1_q) ? mode_req : deb_q;

        case (state_q)
            ST_OFF: begin
                target_d = MODE_NONE;
                gap_d    = '0;
                // Both buttons pressed together never count as a hold.
                if (pwr_on_btn && !pwr_off_btn) begin
                    if (hold_q == HOLD_W'(PWR_HOLD - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (pwr_off_btn) begin
                    state_d = ST_OFF;
                end else if (deb_q != MODE_NONE) begin
                    target_d = deb_q;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (pwr_off_btn) begin
                    state_d = ST_OFF;
                end else if (deb_q != target_q) begin
                    // Changed mind mid-gap: new target, full gap again.
                    target_d = deb_q;
                    gap_d    = '0;
                end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = (target_q == MODE_NONE) ? ST_IDLE : ST_RUN;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (pwr_off_btn || fault_c) begin
                    state_d = ST_OFF;
                end else if (deb_q != mode_q) begin
                    target_d = deb_q;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin : output_comb
        mode_d    = (state_d == ST_RUN) ? target_d : MODE_NONE;
        power_d   = (state_d != ST_OFF);
        busy_d    = (state_d == ST_GAP);
        car_out_d = 8'h00;
        case (mode_d)
            MODE_MAN:  car_out_d = man_out;
            MODE_SEMI: car_out_d = semi_out;
            MODE_AUTO: car_out_d = auto_out;
            default:   car_out_d = 8'h00;
        endcase
    end

    // Counters, debounce and output registers.
    always_ff @(posedge clk) begin : data_reg
        if (rst) begin
            hold_q    <= '0;
            gap_q     <= '0;
            target_q  <= MODE_NONE;
            req_s1_q  <= MODE_NONE;
            deb_q     <= MODE_NONE;
            mode_q    <= MODE_NONE;
            car_out_q <= 8'h00;
            power_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            target_q  <= target_d;
            req_s1_q  <= req_s1_d;
            deb_q     <= deb_d;
            mode_q    <= mode_d;
            car_out_q <= car_out_d;
            power_q   <= power_d;
            busy_q    <= busy_d;
        end
    end

    assign mode    = mode_q;
    assign car_out = car_out_q;
    assign power   = power_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Testbench for drive_mode_arbiter: directed stimulus, a behavioural model
// checked every cycle, and literal expectations at key points.

module tb_drive_mode_arbiter;

    localparam int PWR_HOLD   = 16;
    localparam int GAP_CYCLES = 8;
`ifdef FAULT_SHUTDOWN_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    localparam int M_OFF  = 0;
    localparam int M_IDLE = 1;
    localparam int M_GAP  = 2;
    localparam int M_RUN  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_on_btn;
    logic       pwr_off_btn;
    logic [1:0] mode_req;
    logic [7:0] man_out;
    logic       man_p;
    logic [7:0] semi_out;
    logic [7:0] auto_out;
    logic [1:0] mode;
    logic [7:0] car_out;
    logic       power;
    logic       busy;

    int total = 0;
    int bad   = 0;

    drive_mode_arbiter #(
        .PWR_HOLD  (PWR_HOLD),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwr_on_btn (pwr_on_btn),
        .pwr_off_btn(pwr_off_btn),
        .mode_req   (mode_req),
        .man_out    (man_out),
        .man_p      (man_p),
        .semi_out   (semi_out),
        .auto_out   (auto_out),
        .mode       (mode),
        .car_out    (car_out),
        .power      (power),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the car should see, from the button/request rules.
    bit model_ok = 1'b0;
    int m_state, m_hold, m_prev, m_deb, m_target, m_gap_left, m_run_n, m_mode;
    int e_mode, e_car, e_power, e_busy;
    int seen;

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_OFF; m_hold = 0; m_prev = 0; m_deb = 0;
            m_target = 0; m_gap_left = 0; m_run_n = 0; m_mode = 0;
            model_ok = 1'b1;
        end else begin
            seen = m_deb;
            if (int'(mode_req) == m_prev) m_deb = int'(mode_req);
            m_prev = int'(mode_req);
            if (m_state == M_OFF) begin
                if (pwr_on_btn && !pwr_off_btn) begin
                    m_hold++;
                    if (m_hold == PWR_HOLD) begin
                        m_state = M_IDLE;
                        m_hold  = 0;
                    end
                end else begin
                    m_hold = 0;
                end
            end else if (pwr_off_btn) begin
                m_state = M_OFF;
            end else if (m_state == M_IDLE) begin
                if (seen != 0) begin
                    m_target = seen; m_gap_left = GAP_CYCLES; m_state = M_GAP;
                end
            end else if (m_state == M_GAP) begin
                if (seen != m_target) begin
                    m_target = seen; m_gap_left = GAP_CYCLES;
                end else begin
                    m_gap_left--;
                    if (m_gap_left == 0) begin
                        if (m_target == 0) m_state = M_IDLE;
                        else begin
                            m_state = M_RUN; m_mode = m_target; m_run_n = 0;
                        end
                    end
                end
            end else begin
                if (FAULT_ON && m_mode == 1 && m_run_n >= 2 && !man_p) begin
                    m_state = M_OFF;
                end else if (seen != m_mode) begin
                    m_target = seen; m_gap_left = GAP_CYCLES; m_state = M_GAP;
                end else begin
                    m_run_n++;
                end
            end
        end
        e_power = (m_state != M_OFF) ? 1 : 0;
        e_busy  = (m_state == M_GAP) ? 1 : 0;
        e_mode  = (m_state == M_RUN) ? m_mode : 0;
        e_car   = (e_mode == 1) ? int'(man_out) :
                  (e_mode == 2) ? int'(semi_out) :
                  (e_mode == 3) ? int'(auto_out) : 0;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_mode",    32'(mode),    32'(e_mode));
            chk("model_car_out", 32'(car_out), 32'(e_car));
            chk("model_power",   32'(power),   32'(e_power));
            chk("model_busy",    32'(busy),    32'(e_busy));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pwr_on_btn = 1'b0; pwr_off_btn = 1'b0; mode_req = 2'b00;
        man_out = 8'hA5; semi_out = 8'h3C; auto_out = 8'h5A; man_p = 1'b1;
        cyc(2);
        chk("reset_power", 32'(power), 0);
        chk("reset_mode",  32'(mode), 0);
        chk("reset_busy",  32'(busy), 0);
        chk("reset_car",   32'(car_out), 0);
        rst = 1'b0;

        // One cycle short of the hold time.
        pwr_on_btn = 1'b1; cyc(15); pwr_on_btn = 1'b0; cyc(1);
        chk("hold15_power", 32'(power), 0);

        // Both buttons: hold count must be cleared, then only 10 cycles counted.
        pwr_on_btn = 1'b1; pwr_off_btn = 1'b1; cyc(10);
        pwr_off_btn = 1'b0; cyc(10);
        chk("both_btn_power", 32'(power), 0);
        pwr_on_btn = 1'b0; cyc(1);

        // Full hold.
        pwr_on_btn = 1'b1; cyc(15);
        chk("hold16_pre_power", 32'(power), 0);
        cyc(1);
        chk("hold16_power", 32'(power), 1);
        chk("idle_busy", 32'(busy), 0);
        pwr_on_btn = 1'b0;

        // IDLE -> manual.
        mode_req = 2'b01; cyc(2);
        chk("man_debounce_busy", 32'(busy), 0);
        cyc(1);
        chk("man_gap_first_busy", 32'(busy), 1);
        cyc(7);
        chk("man_gap_last_busy", 32'(busy), 1);
        chk("man_gap_last_mode", 32'(mode), 0);
        cyc(1);
        chk("man_run_busy", 32'(busy), 0);
        chk("man_run_mode", 32'(mode), 1);
        chk("man_run_car",  32'(car_out), 32'h A5);

        // Single-cycle glitch on the request.
        cyc(3); mode_req = 2'b10; cyc(1); mode_req = 2'b01; cyc(4);
        chk("glitch_mode", 32'(mode), 1);
        chk("glitch_busy", 32'(busy), 0);

        // manual -> auto.
        mode_req = 2'b11; cyc(3);
        chk("to_auto_gap_mode", 32'(mode), 0);
        chk("to_auto_gap_car",  32'(car_out), 0);
        chk("to_auto_gap_busy", 32'(busy), 1);
        cyc(7);
        chk("to_auto_gap8_mode", 32'(mode), 0);
        chk("to_auto_gap8_car",  32'(car_out), 0);
        cyc(1);
        chk("auto_run_mode", 32'(mode), 3);
        chk("auto_run_car",  32'(car_out), 32'h5A);
        auto_out = 8'hC3; cyc(1);
        chk("auto_follow_car", 32'(car_out), 32'hC3);

        // Request changes mid-gap: gap restarts.
        mode_req = 2'b10; cyc(5);
        mode_req = 2'b01; cyc(10);
        chk("gap_restart_busy", 32'(busy), 1);
        cyc(1);
        chk("gap_restart_mode", 32'(mode), 1);
        chk("gap_restart_done", 32'(busy), 0);

        // Power-off during the 3rd gap cycle.
        mode_req = 2'b10; cyc(5);
        pwr_off_btn = 1'b1; cyc(1);
        chk("off_in_gap_power", 32'(power), 0);
        chk("off_in_gap_busy",  32'(busy), 0);
        chk("off_in_gap_mode",  32'(mode), 0);
        pwr_off_btn = 1'b0;

        // Manual run with man_p dropping.
        mode_req = 2'b00; cyc(3);
        pwr_on_btn = 1'b1; cyc(16); pwr_on_btn = 1'b0;
        chk("repower_power", 32'(power), 1);
        mode_req = 2'b01; cyc(11);
        chk("fault_run_mode", 32'(mode), 1);
        cyc(1);
        man_p = 1'b0; cyc(1);
        chk("fault_early_power", 32'(power), 1);
        chk("fault_early_mode",  32'(mode), 1);
        man_p = 1'b1; cyc(2);
        man_p = 1'b0; cyc(1);
        if (FAULT_ON) begin
            chk("fault_power", 32'(power), 0);
            chk("fault_mode",  32'(mode), 0);
            chk("fault_car",   32'(car_out), 0);
        end else begin
            chk("nofault_power", 32'(power), 1);
            chk("nofault_mode",  32'(mode), 1);
            chk("nofault_car",   32'(car_out), 32'hA5);
        end
        man_p = 1'b1;

        // Reset in the middle of a handover.
        mode_req = 2'b11; cyc(4);
        rst = 1'b1; cyc(1);
        chk("rst_mid_power", 32'(power), 0);
        chk("rst_mid_busy",  32'(busy), 0);
        chk("rst_mid_mode",  32'(mode), 0);
        chk("rst_mid_car",   32'(car_out), 0);
        rst = 1'b0; cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
